// File: rtl/surf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// surf_wb_arbiter : two-master round-robin WISHBONE arbiter with access watchdog
// Rev 1.0
// ============================================================================
module surf_wb_arbiter #(
    parameter int                ADR_W        = 22,
    parameter int                DAT_W        = 32,
    parameter int                TIMEOUT      = 64,
    parameter logic [DAT_W-1:0]  TIMEOUT_DATA = 32'hDEADDEAD
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic              m0_we_i,
    input  logic [ADR_W-1:0]  m0_adr_i,
    input  logic [DAT_W-1:0]  m0_dat_i,
    output logic              m0_ack_o,
    output logic              m0_err_o,
    output logic [DAT_W-1:0]  m0_dat_o,
    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic              m1_we_i,
    input  logic [ADR_W-1:0]  m1_adr_i,
    input  logic [DAT_W-1:0]  m1_dat_i,
    output logic              m1_ack_o,
    output logic              m1_err_o,
    output logic [DAT_W-1:0]  m1_dat_o,
    output logic              s_cyc_o,
    output logic              s_stb_o,
    output logic              s_we_o,
    output logic [ADR_W-1:0]  s_adr_o,
    output logic [DAT_W-1:0]  s_dat_o,
    input  logic              s_ack_i,
    input  logic              s_err_i,
    input  logic [DAT_W-1:0]  s_dat_i,
    output logic              grant_o,
    output logic [7:0]        tout_count_o
);

    localparam logic [1:0]  ST_IDLE   = 2'd0;
    localparam logic [1:0]  ST_ACTIVE = 2'd1;
    localparam logic [1:0]  ST_ABORT  = 2'd2;
    localparam logic [15:0] TOUT_LAST = 16'(TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic        grant_q, grant_d;
    logic [15:0] tcnt_q, tcnt_d;
    logic [7:0]  tout_q, tout_d;

    logic             g_cyc, g_stb, g_we;
    logic [ADR_W-1:0] g_adr;
    logic [DAT_W-1:0] g_wdat;
    logic             w_tick, w_tout;
    logic             g_ack, g_err;
    logic [DAT_W-1:0] g_rdat;

    assign g_cyc  = grant_q ? m1_cyc_i : m0_cyc_i;
    assign g_stb  = grant_q ? m1_stb_i : m0_stb_i;
    assign g_we   = grant_q ? m1_we_i  : m0_we_i;
    assign g_adr  = grant_q ? m1_adr_i : m0_adr_i;
    assign g_wdat = grant_q ? m1_dat_i : m0_dat_i;

    // A slave response in the final watchdog cycle wins over the abort.
    assign w_tick = (state_q == ST_ACTIVE) && g_cyc && g_stb && !s_ack_i && !s_err_i;
    assign w_tout = w_tick && (tcnt_q == TOUT_LAST);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            grant_q <= 1'b1;
            tcnt_q  <= 16'd0;
            tout_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            tcnt_q  <= tcnt_d;
            tout_q  <= tout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        tcnt_d  = (w_tick && !w_tout) ? tcnt_q + 16'd1 : 16'd0;
        tout_d  = (w_tout && tout_q != 8'hFF) ? tout_q + 8'd1 : tout_q;
        case (state_q)
            ST_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    grant_d = ~grant_q;
                    state_d = ST_ACTIVE;
                end else if (m0_cyc_i) begin
                    grant_d = 1'b0;
                    state_d = ST_ACTIVE;
                end else if (m1_cyc_i) begin
                    grant_d = 1'b1;
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (w_tout)
                    state_d = ST_ABORT;
                else if (!g_cyc)
                    state_d = ST_IDLE;
            end
            ST_ABORT: begin
                if (!g_cyc)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        g_ack   = 1'b0;
        g_err   = 1'b0;
        g_rdat  = '0;
        if (state_q == ST_ACTIVE) begin
            s_cyc_o = g_cyc;
            s_stb_o = g_stb;
            s_we_o  = g_we;
            s_adr_o = g_adr;
            s_dat_o = g_wdat;
            g_ack   = s_ack_i & ~s_err_i;
            g_err   = s_err_i;
            g_rdat  = s_dat_i;
            if (w_tout) begin
                g_err  = 1'b1;
                g_rdat = TIMEOUT_DATA;
            end
        end
        m0_ack_o = g_ack & ~grant_q;
        m0_err_o = g_err & ~grant_q;
        m0_dat_o = grant_q ? '0 : g_rdat;
        m1_ack_o = g_ack & grant_q;
        m1_err_o = g_err & grant_q;
        m1_dat_o = grant_q ? g_rdat : '0;
    end

    assign grant_o      = grant_q;
    assign tout_count_o = tout_q;

endmodule
`default_nettype wire

// File: tb/tb_surf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// tb_surf_wb_arbiter : directed vector bench for surf_wb_arbiter (TIMEOUT=16)
// Rev 1.0
// ============================================================================
module tb_surf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_cyc, m0_stb, m1_cyc, m1_stb;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rdat, m1_rdat;
    logic        s_cyc, s_stb, s_we;
    logic [21:0] s_adr;
    logic [31:0] s_wdat;
    logic        s_ack, s_err;
    logic [31:0] s_rdat;
    logic        grant;
    logic [7:0]  tout_cnt;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    surf_wb_arbiter #(.ADR_W(22), .DAT_W(32), .TIMEOUT(16), .TIMEOUT_DATA(32'hDEADDEAD)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(1'b0), .m0_adr_i(22'h4),
        .m0_dat_i(32'h0000A0A0), .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_dat_o(m0_rdat),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(1'b1), .m1_adr_i(22'h8),
        .m1_dat_i(32'h0000B1B1), .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_dat_o(m1_rdat),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr), .s_dat_o(s_wdat),
        .s_ack_i(s_ack), .s_err_i(s_err), .s_dat_i(s_rdat),
        .grant_o(grant), .tout_count_o(tout_cnt)
    );

    typedef struct {
        logic        m0c, m0s, m1c, m1s, sack, serr;
        logic [31:0] sdat;
        logic [6:0]  flags;   // {s_cyc, s_stb, grant, m0_ack, m0_err, m1_ack, m1_err}
        logic [31:0] m0d, m1d;
        logic [21:0] sadr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic m0c, m0s, m1c, m1s, sack, serr,
                                input logic [31:0] sdat, input logic [6:0] flags,
                                input logic [31:0] m0d, m1d, input logic [21:0] sadr);
        vec_t v;
        v.m0c = m0c; v.m0s = m0s; v.m1c = m1c; v.m1s = m1s;
        v.sack = sack; v.serr = serr; v.sdat = sdat; v.flags = flags;
        v.m0d = m0d; v.m1d = m1d; v.sadr = sadr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic a, b, c, d, e, f, input logic [31:0] dat);
        m0_cyc = a; m0_stb = b; m1_cyc = c; m1_stb = d; s_ack = e; s_err = f; s_rdat = dat;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 32'h0);

        // Both request together out of reset, then alternate
        vecs.push_back(mk(1,1,1,1,0,0,32'h0,        7'b0010000, 32'h0, 32'h0, 22'h0));
        vecs.push_back(mk(1,1,1,1,1,0,32'hA1A1A1A1, 7'b1101000, 32'hA1A1A1A1, 32'h0, 22'h4));
        vecs.push_back(mk(0,0,1,1,0,0,32'h0,        7'b0000000, 32'h0, 32'h0, 22'h4));
        vecs.push_back(mk(0,0,1,1,0,0,32'h0,        7'b0000000, 32'h0, 32'h0, 22'h0));
        vecs.push_back(mk(0,0,1,1,1,0,32'hB1B1B1B1, 7'b1110010, 32'h0, 32'hB1B1B1B1, 22'h8));
        vecs.push_back(mk(0,0,0,0,0,0,32'h0,        7'b0010000, 32'h0, 32'h0, 22'h8));
        vecs.push_back(mk(1,1,1,1,0,0,32'h0,        7'b0010000, 32'h0, 32'h0, 22'h0));
        vecs.push_back(mk(1,1,1,1,1,0,32'hC1C1C1C1, 7'b1101000, 32'hC1C1C1C1, 32'h0, 22'h4));
        vecs.push_back(mk(0,0,0,0,0,0,32'h0,        7'b0000000, 32'h0, 32'h0, 22'h4));
        vecs.push_back(mk(0,0,0,0,0,0,32'h0,        7'b0000000, 32'h0, 32'h0, 22'h0));
        // Master 0 alone, slave acks 3 cycles after stb
        vecs.push_back(mk(1,1,0,0,0,0,32'h0,        7'b0000000, 32'h0, 32'h0, 22'h0));
        vecs.push_back(mk(1,1,0,0,0,0,32'h0,        7'b1100000, 32'h0, 32'h0, 22'h4));
        vecs.push_back(mk(1,1,0,0,0,0,32'h0,        7'b1100000, 32'h0, 32'h0, 22'h4));
        vecs.push_back(mk(1,1,0,0,0,0,32'h0,        7'b1100000, 32'h0, 32'h0, 22'h4));
        vecs.push_back(mk(1,1,0,0,1,0,32'h12345678, 7'b1101000, 32'h12345678, 32'h0, 22'h4));
        vecs.push_back(mk(0,0,0,0,0,0,32'h0,        7'b0000000, 32'h0, 32'h0, 22'h4));
        // m1 holds cyc across 3 strobes; m0 requests from the 2nd
        vecs.push_back(mk(0,0,1,1,0,0,32'h0,        7'b0000000, 32'h0, 32'h0, 22'h0));
        vecs.push_back(mk(0,0,1,1,1,0,32'hD1D1D1D1, 7'b1110010, 32'h0, 32'hD1D1D1D1, 22'h8));
        vecs.push_back(mk(1,1,1,0,0,0,32'h0,        7'b1010000, 32'h0, 32'h0, 22'h8));
        vecs.push_back(mk(1,1,1,1,1,0,32'hD2D2D2D2, 7'b1110010, 32'h0, 32'hD2D2D2D2, 22'h8));
        vecs.push_back(mk(1,1,1,0,0,0,32'h0,        7'b1010000, 32'h0, 32'h0, 22'h8));
        vecs.push_back(mk(1,1,1,1,1,0,32'hD3D3D3D3, 7'b1110010, 32'h0, 32'hD3D3D3D3, 22'h8));
        vecs.push_back(mk(1,1,0,0,0,0,32'h0,        7'b0010000, 32'h0, 32'h0, 22'h8));
        vecs.push_back(mk(1,1,0,0,0,0,32'h0,        7'b0010000, 32'h0, 32'h0, 22'h0));
        vecs.push_back(mk(1,1,0,0,1,1,32'hE1E1E1E1, 7'b1100100, 32'hE1E1E1E1, 32'h0, 22'h4));
        vecs.push_back(mk(0,0,0,0,0,0,32'h0,        7'b0000000, 32'h0, 32'h0, 22'h4));

        #1;
        chk("reset_flags", {25'h0, s_cyc, s_stb, grant, m0_ack, m0_err, m1_ack, m1_err}, 32'h10);
        chk("reset_tout", {24'h0, tout_cnt}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].m0c, vecs[i].m0s, vecs[i].m1c, vecs[i].m1s,
                  vecs[i].sack, vecs[i].serr, vecs[i].sdat);
            #1;
            chk($sformatf("row%0d_flags", i),
                {25'h0, s_cyc, s_stb, grant, m0_ack, m0_err, m1_ack, m1_err}, {25'h0, vecs[i].flags});
            chk($sformatf("row%0d_m0dat", i), m0_rdat, vecs[i].m0d);
            chk($sformatf("row%0d_m1dat", i), m1_rdat, vecs[i].m1d);
            chk($sformatf("row%0d_sadr", i), {10'h0, s_adr}, {10'h0, vecs[i].sadr});
            tick();
        end

        // Watchdog abort: no response for 16 stb cycles
        drive(1, 1, 0, 0, 0, 0, 32'h0);
        tick();
        for (int i = 1; i <= 16; i++) begin
            s_rdat = 32'h11111111;
            #1;
            chk($sformatf("tout_err_c%0d", i), {31'h0, m0_err}, {31'h0, (i == 16)});
            if (i == 16) begin
                chk("tout_dat", m0_rdat, 32'hDEADDEAD);
                chk("tout_ack", {31'h0, m0_ack}, 32'h0);
                chk("tout_cnt_before", {24'h0, tout_cnt}, 32'h0);
            end
            tick();
        end
        chk("abort_scyc", {31'h0, s_cyc}, 32'h0);
        chk("abort_cnt", {24'h0, tout_cnt}, 32'h1);
        s_ack = 1'b1;
        #1;
        chk("abort_late_ack", {31'h0, m0_ack}, 32'h0);
        chk("abort_late_dat", m0_rdat, 32'h0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 32'h0);
        tick();

        // Ack arriving on the 16th stb cycle completes normally
        drive(1, 1, 0, 0, 0, 0, 32'h0);
        tick();
        for (int i = 1; i <= 16; i++) begin
            s_ack  = (i == 16);
            s_rdat = (i == 16) ? 32'hCAFEF00D : 32'h0;
            #1;
            if (i == 16) begin
                chk("edge_ack", {31'h0, m0_ack}, 32'h1);
                chk("edge_err", {31'h0, m0_err}, 32'h0);
                chk("edge_dat", m0_rdat, 32'hCAFEF00D);
            end
            tick();
        end
        s_ack = 1'b0;
        #1;
        chk("edge_cnt", {24'h0, tout_cnt}, 32'h1);
        chk("edge_scyc", {31'h0, s_cyc}, 32'h1);
        drive(0, 0, 0, 0, 0, 0, 32'h0);
        tick();

        // Asynchronous reset in the middle of an m1 access
        drive(0, 0, 1, 1, 0, 0, 32'h0);
        tick();
        s_ack = 1'b1;
        #1;
        chk("pre_rst_m1ack", {31'h0, m1_ack}, 32'h1);
        chk("pre_rst_we", {31'h0, s_we}, 32'h1);
        chk("pre_rst_wdat", s_wdat, 32'h0000B1B1);
        rst = 1'b1;
        #1;
        chk("rst_scyc", {31'h0, s_cyc}, 32'h0);
        chk("rst_m1ack", {31'h0, m1_ack}, 32'h0);
        chk("rst_tout", {24'h0, tout_cnt}, 32'h0);
        chk("rst_grant", {31'h0, grant}, 32'h1);
        #1;
        rst = 1'b0;
        drive(1, 1, 1, 1, 0, 0, 32'h0);
        tick();
        chk("post_rst_grant", {31'h0, grant}, 32'h0);
        chk("post_rst_scyc", {31'h0, s_cyc}, 32'h1);
        chk("post_rst_adr", {10'h0, s_adr}, 32'h4);
        drive(0, 0, 0, 0, 0, 0, 32'h0);
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/surf_wb_arbiter.md
Name: surf_wb_arbiter

Overview:
- Two-master, one-slave WISHBONE arbiter for the SURF register space, on the 62.5 MHz register clock.
- Master 0 is the serial (UART/EMIO) command path; master 1 is the high-speed TURFIO command path.
- Round-robin grant, with grant held for the full duration of the winner's cyc.
- Per-access timeout watchdog: terminates any slave access that never acks, returning an error to the master so the register bus cannot hang.

Parameters:
- ADR_W, 22, address width.
- DAT_W, 32, data width.
- TIMEOUT, 64, stb cycles without ack/err before abort (valid range 2..65535).
- TIMEOUT_DATA, 32'hDEADDEAD, data returned to the master with a timeout error.

Ports:
- wb_clk_i  in  1  register clock.
- wb_rst_i  in  1  asynchronous active-high reset.
- mN_cyc_i  in  1  (N=0,1) master cycle.
- mN_stb_i  in  1  master strobe.
- mN_we_i  in  1  master write enable.
- mN_adr_i  in  ADR_W  master address.
- mN_dat_i  in  DAT_W  master write data.
- mN_ack_o  out  1  ack to master.
- mN_err_o  out  1  error to master.
- mN_dat_o  out  DAT_W  read data to master.
- s_cyc_o  out  1  slave cycle.
- s_stb_o  out  1  slave strobe.
- s_we_o  out  1  slave write enable.
- s_adr_o  out  ADR_W  slave address.
- s_dat_o  out  DAT_W  slave write data.
- s_ack_i  in  1  slave ack.
- s_err_i  in  1  slave error.
- s_dat_i  in  DAT_W  slave read data.
- grant_o  out  1  current/last granted master index.
- tout_count_o  out  8  saturating count of timeouts since reset.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; every output 0 (grant_o=1, see below).
  - last_grant=1, so master 0 wins the first tie; grant_o reflects last_grant = 1.
  - Timeout counter 0; tout_count_o 0.
- States: IDLE, ACTIVE, ABORT.
- IDLE:
  - All s_* outputs 0; all mN_ack_o/err_o 0.
  - If exactly one mN_cyc_i is high, grant that master.
  - If both are high, grant ~last_grant.
  - Grant is registered: state goes to ACTIVE at the next edge, and grant_o updates at that edge.
  - Minimum latency from cyc to s_cyc_o is 1 cycle.
- ACTIVE:
  - s_cyc/stb/we/adr/dat_o = granted master's inputs (combinational mux).
  - mG_ack_o = s_ack_i & ~s_err_i; mG_err_o = s_err_i; mG_dat_o = s_dat_i.
  - Non-granted master sees ack=err=0 and dat=0.
  - Grant is held while mG_cyc_i stays high (multi-strobe lock); the other master waits regardless of its request.
  - When mG_cyc_i drops: last_grant<=G, go to IDLE. s_cyc_o drops the same cycle (combinational).
  - A new arbitration then takes one IDLE cycle.
- Timeout counter (16-bit):
  - Increments each ACTIVE cycle with s_stb_o=1 and s_ack_i=0 and s_err_i=0.
  - Clears on ack, on err, or when stb is low.
  - If ack/err and counter==TIMEOUT-1 occur in the same cycle, ack/err wins: normal completion, counter clears.
- Abort on timeout:
  - When the counter reaches TIMEOUT-1 with still no response, assert mG_err_o=1 and mG_dat_o=TIMEOUT_DATA for exactly that cycle.
  - In that cycle, increment tout_count_o (saturating at 255) and go to ABORT.
- ABORT:
  - s_cyc_o=s_stb_o=0; master outputs 0.
  - Late s_ack_i/s_err_i are ignored.
  - Stay until mG_cyc_i=0, then last_grant<=G and go to IDLE.
- A master that drops cyc mid-strobe before ack forfeits the access; no error is generated.
- Reset asserted mid-transaction: everything goes to reset values immediately; tout_count_o is cleared.

Test Plan:
- Master 0 alone reads adr 0x4; slave acks 3 cycles after stb with 0x12345678 -> s_cyc_o rises 1 cycle after m0_cyc_i; m0_ack_o one cycle with m0_dat_o=0x12345678; grant_o=0; m1 outputs stay 0.
- Both masters raise cyc together out of reset; each does one single-ack access -> m0 served first, then after one IDLE cycle m1 (grant_o=1). Both re-request -> m0 again.
- m1 holds cyc across 3 strobes while m0 requests from the 2nd strobe -> all 3 strobes reach the slave from m1; m0 is granted only after m1_cyc_i falls.
- TIMEOUT=16, slave never responds to m0 -> m0_err_o pulses on the 16th stb cycle with m0_dat_o=0xDEADDEAD; s_cyc_o is low the next cycle; tout_count_o=1. A late s_ack_i is not forwarded.
- Slave ack on exactly the 16th stb cycle (TIMEOUT=16) -> m0_ack_o=1, m0_err_o=0, tout_count_o unchanged.
- wb_rst_i pulsed mid-access on m1 -> s_cyc_o, m1_ack_o and tout_count_o all 0 asynchronously; grant_o=1. After release, a simultaneous request is granted to m0.
